// File: rtl/alu_wb_if.sv
// alu_wb_if: Alu-result input and register-file write buses for alu_writeback_stage.
//  master: upstream/register-file side (drives in_*, rf_ready).
//  slave : the writeback stage (drives in_ready, rf_*, flags_to_alu, flags_hazard).
//  in_wr_flags is nonzero when the entry updates the flags register.
interface alu_wb_if #(
    parameter int WORD_WIDTH = 32,
    parameter int REG_IDX_W  = 4,
    parameter int FLAGS_W    = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_WIDTH-1:0] in_result;
    logic [FLAGS_W-1:0]    in_flags;
    logic [REG_IDX_W-1:0]  in_rd;
    logic                  in_wr_reg;
    logic [FLAGS_W-1:0]    in_wr_flags;
    logic [FLAGS_W-1:0]    flags_to_alu;
    logic                  flags_hazard;
    logic                  rf_valid;
    logic                  rf_ready;
    logic [REG_IDX_W-1:0]  rf_addr;
    logic [WORD_WIDTH-1:0] rf_data;
    modport master (
        output in_valid, in_result, in_flags, in_rd, in_wr_reg, in_wr_flags, rf_ready,
        input  in_ready, flags_to_alu, flags_hazard, rf_valid, rf_addr, rf_data
    );
    modport slave (
        input  in_valid, in_result, in_flags, in_rd, in_wr_reg, in_wr_flags, rf_ready,
        output in_ready, flags_to_alu, flags_hazard, rf_valid, rf_addr, rf_data
    );
endinterface

// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: 2-entry skid FIFO from the Alu to the register-file write port,
// plus the architectural flags register fed back to the Alu.
//  clk, rst : rising-edge clock, synchronous active-high reset
//  bus      : alu_wb_if.slave (in_* accept side, rf_* write side, flags_to_alu/flags_hazard)
//  Macro FLARE32_WB_FLAG_BYPASS_EN: forward the youngest buffered flag write to
//  flags_to_alu (flags_hazard tied 0); undefined, flags_to_alu is flags_reg only and
//  flags_hazard reports any buffered flag write.
module alu_writeback_stage #(
    parameter int WORD_WIDTH = 32,
    parameter int REG_IDX_W  = 4,
    parameter int FLAGS_W    = 4
) (
    input logic    clk,
    input logic    rst,
    alu_wb_if.slave bus
);
    logic [WORD_WIDTH-1:0] result_q [2];
    logic [FLAGS_W-1:0]    flags_q  [2];
    logic [REG_IDX_W-1:0]  rd_q     [2];
    logic [1:0]            wr_reg_q;
    logic [1:0]            wr_flags_q;
    logic                  wp;
    logic                  rp;
    logic                  yp;
    logic [1:0]            count;
    logic [1:0]            count_nxt;
    logic                  in_ready_q;
    logic [FLAGS_W-1:0]    flags_reg;
    logic                  head_valid;
    logic                  push;
    logic                  pop;

    assign head_valid = count != 2'd0;
    assign push       = bus.in_valid & in_ready_q;
    // Non-GPR entries retire without waiting for the register-file port.
    assign pop        = head_valid & (bus.rf_ready | ~wr_reg_q[rp]);
    assign count_nxt  = count + {1'b0, push} - {1'b0, pop};
    // Youngest buffered entry sits just behind the write pointer.
    assign yp         = ~wp;

    assign bus.in_ready = in_ready_q;
    assign bus.rf_valid = head_valid & wr_reg_q[rp];
    assign bus.rf_addr  = head_valid ? rd_q[rp] : '0;
    assign bus.rf_data  = head_valid ? result_q[rp] : '0;

`ifdef FLARE32_WB_FLAG_BYPASS_EN
    assign bus.flags_to_alu = (head_valid & wr_flags_q[yp]) ? flags_q[yp] :
                              (count[1] & wr_flags_q[rp])   ? flags_q[rp] : flags_reg;
    assign bus.flags_hazard = 1'b0;
`else
    assign bus.flags_to_alu = flags_reg;
    assign bus.flags_hazard = (head_valid & wr_flags_q[rp]) | (count[1] & wr_flags_q[yp]);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= 2'd0;
            wp         <= 1'b0;
            rp         <= 1'b0;
            in_ready_q <= 1'b1;
            flags_reg  <= '0;
        end else begin
            count      <= count_nxt;
            // Registered from the next-state count: no rf_ready-to-in_ready path.
            in_ready_q <= ~count_nxt[1];
            if (push) wp <= ~wp;
            if (pop) rp <= ~rp;
            if (pop & wr_flags_q[rp]) flags_reg <= flags_q[rp];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            result_q[wp]   <= bus.in_result;
            flags_q[wp]    <= bus.in_flags;
            rd_q[wp]       <= bus.in_rd;
            wr_reg_q[wp]   <= bus.in_wr_reg;
            wr_flags_q[wp] <= |bus.in_wr_flags;
        end
    end
endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb_alu_writeback_stage: directed and randomized checks against a queue-based model.
module tb_alu_writeback_stage;
    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  flags;
        logic [3:0]  rd;
        logic        wr_reg;
        logic        wr_flags;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    ent_t q[$];
    logic [3:0] m_flags = 4'b0;
    logic [31:0] wlog[$];

    alu_wb_if #(.WORD_WIDTH(32), .REG_IDX_W(4), .FLAGS_W(4)) bus ();
    alu_writeback_stage #(.WORD_WIDTH(32), .REG_IDX_W(4), .FLAGS_W(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

`ifdef FLARE32_WB_FLAG_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    function automatic logic [3:0] exp_fta();
        for (int i = q.size() - 1; i >= 0; i--)
            if (BYPASS && q[i].wr_flags) return q[i].flags;
        return m_flags;
    endfunction

    function automatic logic exp_haz();
        if (BYPASS) return 1'b0;
        foreach (q[i]) if (q[i].wr_flags) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_rfv();
        return q.size() > 0 && q[0].wr_reg;
    endfunction

    // One clock: decide push/pop from the model, advance the model at the edge.
    task automatic tick();
        ent_t e;
        logic push, pop;
        e = '{bus.in_result, bus.in_flags, bus.in_rd, bus.in_wr_reg, bus.in_wr_flags != 4'b0};
        push = bus.in_valid && q.size() < 2;
        pop  = q.size() > 0 && (bus.rf_ready || !q[0].wr_reg);
        if (!rst && bus.rf_valid && bus.rf_ready) wlog.push_back(bus.rf_data);
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_flags = 4'b0;
        end else begin
            if (pop) begin
                if (q[0].wr_flags) m_flags = q[0].flags;
                void'(q.pop_front());
            end
            if (push) q.push_back(e);
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic [3:0] f,
                         input logic [3:0] rd, input logic wr, input logic wf);
        bus.in_valid = v; bus.in_result = r; bus.in_flags = f;
        bus.in_rd = rd; bus.in_wr_reg = wr; bus.in_wr_flags = {3'b0, wf};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        bus.rf_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        tests++; if (bus.rf_valid !== 1'b0) begin fails++; $display("FAIL reset_rf_valid got %b want 0", bus.rf_valid); end
        tests++; if (bus.flags_to_alu !== 4'b0) begin fails++; $display("FAIL reset_flags got %b want 0000", bus.flags_to_alu); end
        tests++; if (bus.flags_hazard !== 1'b0) begin fails++; $display("FAIL reset_hazard got %b want 0", bus.flags_hazard); end
        tests++; if ({bus.rf_addr, bus.rf_data} !== 36'b0) begin fails++; $display("FAIL reset_rf_bus got %h/%h want 0/0", bus.rf_addr, bus.rf_data); end
    endtask

    task automatic test_single_write();
        bus.rf_ready = 1'b1;
        drive(1, 32'hDEADBEEF, 0, 4'd5, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tests++; if (bus.rf_valid !== 1'b1) begin fails++; $display("FAIL single_rf_valid got %b want 1", bus.rf_valid); end
        tests++; if (bus.rf_addr !== 4'd5) begin fails++; $display("FAIL single_rf_addr got %0d want 5", bus.rf_addr); end
        tests++; if (bus.rf_data !== 32'hDEADBEEF) begin fails++; $display("FAIL single_rf_data got %h want deadbeef", bus.rf_data); end
        tick();
        tests++; if (bus.rf_valid !== 1'b0 || bus.rf_data !== 32'b0) begin fails++; $display("FAIL single_empty got v=%b d=%h want v=0 d=0", bus.rf_valid, bus.rf_data); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp[3];
        exp = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
        wlog.delete();
        bus.rf_ready = 1'b0;
        drive(1, exp[0], 0, 4'd1, 1, 0); tick();
        drive(1, exp[1], 0, 4'd2, 1, 0); tick();
        drive(1, exp[2], 0, 4'd3, 1, 0);
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready); end
        tick();
        tests++; if (bus.in_ready !== 1'b0 || bus.rf_data !== exp[0]) begin fails++; $display("FAIL bp_stall got rdy=%b d=%h want rdy=0 d=%h", bus.in_ready, bus.rf_data, exp[0]); end
        bus.rf_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (bus.in_valid && q.size() < 2) begin
                tick();
                drive(0, 0, 0, 0, 0, 0);
            end else tick();
        end
        tests++; if (wlog.size() !== 3) begin fails++; $display("FAIL bp_write_count got %0d want 3", wlog.size()); end
        for (int i = 0; i < 3 && i < wlog.size(); i++) begin
            tests++; if (wlog[i] !== exp[i]) begin fails++; $display("FAIL bp_order[%0d] got %h want %h", i, wlog[i], exp[i]); end
        end
    endtask

    task automatic test_flag_update();
        bus.rf_ready = 1'b0;
        drive(1, 32'h1234, 4'b1000, 4'd7, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tests++; if (bus.rf_valid !== 1'b0) begin fails++; $display("FAIL flag_rf_valid got %b want 0", bus.rf_valid); end
        tests++; if (bus.flags_to_alu !== (BYPASS ? 4'b1000 : 4'b0000)) begin fails++; $display("FAIL flag_pending_fta got %b want %b", bus.flags_to_alu, BYPASS ? 4'b1000 : 4'b0000); end
        tick();
        tests++; if (bus.flags_to_alu !== 4'b1000 || bus.flags_hazard !== 1'b0) begin fails++; $display("FAIL flag_retired got f=%b h=%b want f=1000 h=0", bus.flags_to_alu, bus.flags_hazard); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL flag_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_bypass();
        bus.rf_ready = 1'b0;
        drive(1, 32'h55, 4'b0110, 4'd9, 1, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            tests++; if (bus.flags_to_alu !== (BYPASS ? 4'b0110 : 4'b1000)) begin fails++; $display("FAIL bypass_fta[%0d] got %b want %b", i, bus.flags_to_alu, BYPASS ? 4'b0110 : 4'b1000); end
            tests++; if (bus.flags_hazard !== !BYPASS) begin fails++; $display("FAIL bypass_hazard[%0d] got %b want %b", i, bus.flags_hazard, !BYPASS); end
            tick();
        end
        bus.rf_ready = 1'b1;
        tick();
        tests++; if (bus.flags_to_alu !== 4'b0110 || bus.flags_hazard !== 1'b0) begin fails++; $display("FAIL bypass_retired got f=%b h=%b want f=0110 h=0", bus.flags_to_alu, bus.flags_hazard); end
    endtask

    task automatic test_reset_mid();
        bus.rf_ready = 1'b0;
        drive(1, 32'h111, 4'b0011, 4'd1, 1, 1); tick();
        drive(1, 32'h222, 4'b0101, 4'd2, 1, 1); tick();
        drive(0, 0, 0, 0, 0, 0);
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL mid_full got %b want 0", bus.in_ready); end
        rst = 1'b1; tick(); rst = 1'b0;
        tests++; if (bus.rf_valid !== 1'b0 || bus.in_ready !== 1'b1) begin fails++; $display("FAIL mid_reset got v=%b rdy=%b want v=0 rdy=1", bus.rf_valid, bus.in_ready); end
        tests++; if (bus.flags_to_alu !== 4'b0 || bus.flags_hazard !== 1'b0) begin fails++; $display("FAIL mid_flags got f=%b h=%b want 0000/0", bus.flags_to_alu, bus.flags_hazard); end
        bus.rf_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (bus.rf_valid !== 1'b0) begin fails++; $display("FAIL mid_no_write[%0d] got %b want 0", i, bus.rf_valid); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 2) != 0, $urandom, 4'($urandom), 4'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
            bus.rf_ready = $urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 7 : 2);
            tick();
            tests++; if (bus.in_ready !== (q.size() < 2)) begin fails++; $display("FAIL rnd_in_ready @%0d got %b want %b", i, bus.in_ready, q.size() < 2); end
            tests++; if (bus.rf_valid !== exp_rfv()) begin fails++; $display("FAIL rnd_rf_valid @%0d got %b want %b", i, bus.rf_valid, exp_rfv()); end
            tests++; if (bus.rf_addr !== (q.size() > 0 ? q[0].rd : 4'b0)) begin fails++; $display("FAIL rnd_rf_addr @%0d got %h want %h", i, bus.rf_addr, q.size() > 0 ? q[0].rd : 4'b0); end
            tests++; if (bus.rf_data !== (q.size() > 0 ? q[0].result : 32'b0)) begin fails++; $display("FAIL rnd_rf_data @%0d got %h want %h", i, bus.rf_data, q.size() > 0 ? q[0].result : 32'b0); end
            tests++; if (bus.flags_to_alu !== exp_fta()) begin fails++; $display("FAIL rnd_fta @%0d got %b want %b", i, bus.flags_to_alu, exp_fta()); end
            tests++; if (bus.flags_hazard !== exp_haz()) begin fails++; $display("FAIL rnd_hazard @%0d got %b want %b", i, bus.flags_hazard, exp_haz()); end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_backpressure();
        test_flag_update();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
